// File: rtl/switch_allocator.sv
// switch_allocator: wormhole crossbar allocator, per-output round-robin arbitration with packet locking
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   send       input i presents a flit
//   dest       field i = routed output port of input i
//   isHead     flit at input i is a head
//   isTail     flit at input i is a tail (head+tail = single-flit packet)
//   out_ready  output buffer o can accept a flit
//   sel        field o = input index driving output o
//   out_valid  output o carries a valid flit
//   grant      input i's flit is consumed this cycle
// Build option: define SWITCH_ALLOC_FIXED_PRI_EN for fixed lowest-index priority instead of round-robin.
module switch_allocator #(
    parameter int ID               = 0,
    parameter int DESTINATION_BITS = 4,
    parameter int PORT_BITS        = 4,
    parameter int PORT_COUNT       = 5
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [PORT_COUNT-1:0]                  send,
    input  logic [PORT_COUNT*DESTINATION_BITS-1:0] dest,
    input  logic [PORT_COUNT-1:0]                  isHead,
    input  logic [PORT_COUNT-1:0]                  isTail,
    input  logic [PORT_COUNT-1:0]                  out_ready,
    output logic [PORT_BITS*PORT_COUNT-1:0]        sel,
    output logic [PORT_COUNT-1:0]                  out_valid,
    output logic [PORT_COUNT-1:0]                  grant
);
    if (ID < 0 || (1 << PORT_BITS) < PORT_COUNT) begin : g_param_check
        $error("switch_allocator: invalid parameters");
    end
    logic [PORT_COUNT-1:0] locked;
    logic [PORT_BITS-1:0]  owner  [PORT_COUNT];
    logic [PORT_BITS-1:0]  rr_ptr [PORT_COUNT];
    logic [PORT_COUNT-1:0] own    [PORT_COUNT];
    logic [PORT_COUNT-1:0] req    [PORT_COUNT];
    logic [PORT_BITS-1:0]  win    [PORT_COUNT];
    logic [PORT_COUNT-1:0] busy, release_lock, found;
    // own[o][i]: output o is locked to input i
    always_comb begin
        busy = '0;
        grant = '0;
        out_valid = '0;
        release_lock = '0;
        sel = '0;
        for (int o = 0; o < PORT_COUNT; o++) begin
            own[o] = '0;
            sel[o*PORT_BITS +: PORT_BITS] = owner[o];
            for (int i = 0; i < PORT_COUNT; i++) own[o][i] = locked[o] && owner[o] == PORT_BITS'(i);
            out_valid[o] = |(own[o] & send);
            release_lock[o] = |(own[o] & send & isTail) && out_ready[o];
            grant |= own[o] & send & {PORT_COUNT{out_ready[o]}};
            busy |= own[o];
        end
    end
    // Inputs that already own an output are masked, so a tail being transferred
    // cannot win the output it is releasing in the same cycle.
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < PORT_COUNT; o++) begin
            req[o] = '0;
            found[o] = 1'b0;
            win[o] = '0;
            for (int i = 0; i < PORT_COUNT; i++)
                req[o][i] = send[i] && isHead[i] && !busy[i] && 32'(dest[i*DESTINATION_BITS +: DESTINATION_BITS]) == o;
            // descending scan: the last hit is the first requester from rr_ptr
            for (int k = PORT_COUNT - 1; k >= 0; k--) begin
                idx = int'((32'(rr_ptr[o]) + 32'(k)) % PORT_COUNT);
                if (req[o][idx]) begin
                    found[o] = 1'b1;
                    win[o] = PORT_BITS'(idx);
                end
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            locked <= '0;
            for (int o = 0; o < PORT_COUNT; o++) owner[o] <= '0;
        end else begin
            for (int o = 0; o < PORT_COUNT; o++)
                if (!locked[o] || release_lock[o]) begin
                    locked[o] <= found[o];
                    if (found[o]) owner[o] <= win[o];
                end
        end
    end
`ifdef SWITCH_ALLOC_FIXED_PRI_EN
    always_comb for (int o = 0; o < PORT_COUNT; o++) rr_ptr[o] = '0;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < PORT_COUNT; o++) rr_ptr[o] <= '0;
        end else begin
            for (int o = 0; o < PORT_COUNT; o++)
                if ((!locked[o] || release_lock[o]) && found[o])
                    rr_ptr[o] <= (32'(win[o]) == PORT_COUNT - 1) ? '0 : win[o] + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: randomized and directed checks of switch_allocator against a packet-level reference model
module tb_switch_allocator;
    localparam int P = 5, DB = 4, PB = 4;
    logic clk = 1'b0, reset = 1'b0;
    logic [P-1:0] send, isHead, isTail, out_ready, out_valid, grant;
    logic [P*DB-1:0] dest;
    logic [P*PB-1:0] sel;
    switch_allocator #(.ID(0), .DESTINATION_BITS(DB), .PORT_BITS(PB), .PORT_COUNT(P)) dut (
        .clk(clk), .reset(reset), .send(send), .dest(dest), .isHead(isHead), .isTail(isTail),
        .out_ready(out_ready), .sel(sel), .out_valid(out_valid), .grant(grant)
    );
    always #5 clk = ~clk;
    int checks = 0, failures = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask
    // upstream packet sources: circular buffers of (dest, length), fi = flit index in current packet
    int pd [P][16], pl [P][16], hd [P], cnt [P], fi [P];
    logic [P-1:0] en = '1, rdy = '1;
    // reference model: per output lock/owner/round-robin pointer
    int m_locked [P], m_owner [P], m_rr [P], n_locked [P], n_owner [P], n_rr [P];
    int m_grant;
    logic [31:0] obs_grant, obs_valid, obs_sel;
    task automatic push(input int i, input int d, input int len);
        pd[i][(hd[i] + cnt[i]) % 16] = d;
        pl[i][(hd[i] + cnt[i]) % 16] = len;
        cnt[i]++;
    endtask
    task automatic clear_all();
        for (int i = 0; i < P; i++) begin
            cnt[i] = 0; hd[i] = 0; fi[i] = 0;
            m_locked[i] = 0; m_owner[i] = 0; m_rr[i] = 0;
        end
    endtask
    task automatic drive();
        for (int i = 0; i < P; i++) begin
            send[i] = cnt[i] > 0 && en[i];
            isHead[i] = cnt[i] > 0 && fi[i] == 0;
            isTail[i] = cnt[i] > 0 && fi[i] == pl[i][hd[i]] - 1;
            dest[i*DB +: DB] = DB'((cnt[i] > 0 && fi[i] == 0) ? pd[i][hd[i]] : int'($urandom_range(0, 15)));
        end
        out_ready = rdy;
    endtask
    // one clock: present flits, compare outputs mid-cycle, then advance model and sources
    task automatic step();
        int ev, es, busy, start, i;
        drive();
        @(negedge clk);
        m_grant = 0; ev = 0; es = 0; busy = 0;
        for (int o = 0; o < P; o++) begin
            es |= m_owner[o] << (o * PB);
            if (m_locked[o] != 0) begin
                busy |= 1 << m_owner[o];
                if (send[m_owner[o]]) begin
                    ev |= 1 << o;
                    if (out_ready[o]) m_grant |= 1 << m_owner[o];
                end
            end
        end
        check("grant", grant, m_grant);
        check("out_valid", out_valid, ev);
        check("sel", sel, es);
        obs_grant = grant; obs_valid = out_valid; obs_sel = sel;
        for (int o = 0; o < P; o++) begin
            n_locked[o] = m_locked[o]; n_owner[o] = m_owner[o]; n_rr[o] = m_rr[o];
            if (m_locked[o] == 0 || (ev[o] && out_ready[o] && isTail[m_owner[o]])) begin
                n_locked[o] = 0;
`ifdef SWITCH_ALLOC_FIXED_PRI_EN
                start = 0;
`else
                start = m_rr[o];
`endif
                for (int k = 0; k < P; k++) begin
                    i = (start + k) % P;
                    if (n_locked[o] == 0 && send[i] && isHead[i] && !busy[i] && int'(dest[i*DB +: DB]) == o) begin
                        n_locked[o] = 1;
                        n_owner[o] = i;
`ifdef SWITCH_ALLOC_FIXED_PRI_EN
                        n_rr[o] = 0;
`else
                        n_rr[o] = (i + 1) % P;
`endif
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int o = 0; o < P; o++) begin
            m_locked[o] = n_locked[o]; m_owner[o] = n_owner[o]; m_rr[o] = n_rr[o];
        end
        for (int j = 0; j < P; j++)
            if (m_grant[j]) begin
                fi[j]++;
                if (fi[j] == pl[j][hd[j]]) begin
                    fi[j] = 0; hd[j] = (hd[j] + 1) % 16; cnt[j]--;
                end
            end
    endtask
`ifdef SWITCH_ALLOC_FIXED_PRI_EN
    int t2 [5] = '{0, 1, 2, 1, 16};
`else
    int t2 [5] = '{0, 1, 2, 16, 1};
`endif
    int t3 [7] = '{0, 2, 2, 2, 2, 2, 8};
    initial begin
        clear_all();
        repeat (3) begin
            @(posedge clk);
            #1;
            send = P'($urandom); isHead = P'($urandom); isTail = P'($urandom);
            out_ready = P'($urandom); dest = (P*DB)'($urandom);
            @(negedge clk);
            check("rst_sel", sel, 0);
            check("rst_valid", out_valid, 0);
            check("rst_grant", grant, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        // first head after reset: input 2 -> output 3
        push(2, 3, 1);
        step(); check("t1_lock_cycle", obs_grant, 0);
        step(); check("t1_grant", obs_grant, 4);
        check("t1_sel3", obs_sel[15:12], 2);
        check("t1_valid", obs_valid, 8);
        repeat (2) step();
        // contention on output 2
        push(0, 2, 1); push(0, 2, 1); push(1, 2, 1); push(4, 2, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t2_grant_seq", obs_grant, t2[k]);
        end
        repeat (2) step();
        // wormhole lock: 5-flit packet from input 1 blocks input 3 on output 0
        push(1, 0, 5); push(3, 0, 1);
        for (int k = 0; k < 7; k++) begin
            step();
            check("t3_grant_seq", obs_grant, t3[k]);
        end
        repeat (2) step();
        // backpressure on output 4
        push(2, 4, 4);
        step(); check("t4_lock_cycle", obs_grant, 0);
        step(); check("t4_first", obs_grant, 4);
        rdy = 5'b01111;
        repeat (5) begin
            step();
            check("t4_stall_grant", obs_grant, 0);
            check("t4_stall_valid", obs_valid, 16);
        end
        rdy = '1;
        repeat (3) begin
            step();
            check("t4_resume", obs_grant, 4);
        end
        step(); check("t4_done", obs_valid, 0);
        // all five outputs in parallel
        for (int i = 0; i < P; i++) push(i, (i + 1) % P, 2);
        step(); check("t5_lock_cycle", obs_grant, 0);
        step(); check("t5_all_head", obs_grant, 31);
        check("t5_all_valid", obs_valid, 31);
        step(); check("t5_all_tail", obs_grant, 31);
        step(); check("t5_idle", obs_valid, 0);
        // bad destination never wins
        push(0, 7, 1);
        repeat (5) begin
            step();
            check("t6_bad_dest", obs_grant, 0);
        end
        cnt[0] = 0; hd[0] = 0; fi[0] = 0;
        // reset in the middle of a locked packet
        push(3, 1, 4);
        step(); step(); check("t7_grant", obs_grant, 8);
        drive();
        #1;
        check("t7_pre_valid", out_valid, 2);
        reset = 1'b0;
        #1;
        check("t7_rst_valid", out_valid, 0);
        check("t7_rst_grant", grant, 0);
        check("t7_rst_sel", sel, 0);
        clear_all();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        push(4, 3, 1); push(1, 3, 1);
        step(); check("t7_relock", obs_grant, 0);
        step(); check("t7_rr_zero", obs_grant, 2);
        step(); check("t7_second", obs_grant, 16);
        // randomized traffic with bubbles and backpressure
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int i;
                i = $urandom_range(0, P - 1);
                if (cnt[i] < 8) push(i, $urandom_range(0, P - 1), $urandom_range(1, 4));
            end
            for (int i = 0; i < P; i++) begin
                en[i] = $urandom_range(0, 3) != 0;
                rdy[i] = $urandom_range(0, 3) != 0;
            end
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
